// File: rtl/gpio_in_filter_pkg.sv
// Shared GPIO definitions: register window indices for the input filter block.
package gpio_in_filter_pkg;

  localparam int unsigned ADDR_W = 2;

  typedef enum logic [ADDR_W-1:0] {
    REG_FILT   = 2'd0,
    REG_PERIOD = 2'd1,
    REG_RISE   = 2'd2,
    REG_FALL   = 2'd3
  } reg_e;

endpackage

// File: rtl/gpio_debounce_bit.sv
// One input bit: two-flop synchroniser, two-sample tick history and debounced output.
module gpio_debounce_bit (
  input  logic clk,
  input  logic resetn,
  input  logic tick,
  input  logic pad,
  output logic filt
);

  logic       s1;
  logic       s2;
  logic [1:0] h;

  // The output only follows after three consecutive equal tick samples.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      h    <= 2'b00;
      filt <= 1'b0;
    end else begin
      s1 <= pad;
      s2 <= s1;
      if (tick) begin
        h <= {h[0], s2};
        if ((s2 == h[0]) && (s2 == h[1]) && (s2 != filt)) begin
          filt <= s2;
        end
      end
    end
  end

endmodule

// File: rtl/gpio_in_filter.sv
// Pad input conditioning: debounce prescaler, per-bit filters, edge flags and register window.
module gpio_in_filter
  import gpio_in_filter_pkg::*;
#(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned DEF_PERIOD = 999
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              cs,
  input  logic              wen,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WIDTH-1:0]  din,
  output logic [WIDTH-1:0]  dout,
  input  logic [WIDTH-1:0]  pad_in,
  output logic [WIDTH-1:0]  filt,
  output logic              irq
);

  logic             wr;
  logic             wr_period;
  logic             tick;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] pcnt;
  logic [WIDTH-1:0] filt_d;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] clr_rise;
  logic [WIDTH-1:0] clr_fall;
  logic [WIDTH-1:0] rise_nxt;
  logic [WIDTH-1:0] fall_nxt;

  assign wr        = cs && wen;
  assign wr_period = wr && (addr == REG_PERIOD);
  // A period write restarts the prescaler and suppresses that cycle's tick.
  assign tick      = !wr_period && (pcnt == period);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      period <= CNT_W'(DEF_PERIOD);
      pcnt   <= '0;
    end else if (wr_period) begin
      period <= din[CNT_W-1:0];
      pcnt   <= '0;
    end else if (pcnt == period) begin
      pcnt <= '0;
    end else begin
      pcnt <= pcnt + CNT_W'(1);
    end
  end

  for (genvar i = 0; i < int'(WIDTH); i++) begin : g_bit
    gpio_debounce_bit u_bit (
      .clk    (clk),
      .resetn (resetn),
      .tick   (tick),
      .pad    (pad_in[i]),
      .filt   (filt[i])
    );
  end

  // Set has priority over a same-cycle write-1-to-clear.
  always_comb begin
    clr_rise = '0;
    clr_fall = '0;
    if (wr && (addr == REG_RISE)) clr_rise = din;
    if (wr && (addr == REG_FALL)) clr_fall = din;
    rise_nxt = (rise & ~clr_rise) | (filt & ~filt_d);
    fall_nxt = (fall & ~clr_fall) | (~filt & filt_d);
  end

  // irq is built from the next flag values so it tracks the flags without lag.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      filt_d <= '0;
      rise   <= '0;
      fall   <= '0;
      irq    <= 1'b0;
    end else begin
      filt_d <= filt;
      rise   <= rise_nxt;
      fall   <= fall_nxt;
      irq    <= (|rise_nxt) | (|fall_nxt);
    end
  end

  always_comb begin
    dout = '0;
    case (addr)
      REG_FILT:   dout = filt;
      REG_PERIOD: dout = WIDTH'(period);
      REG_RISE:   dout = rise;
      REG_FALL:   dout = fall;
    endcase
  end

endmodule

// File: tb/tb_gpio_in_filter.sv
// Directed and randomized bench for gpio_in_filter against a sample-window reference model.
module tb_gpio_in_filter;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         resetn;
  logic         cs;
  logic         wen;
  logic [1:0]   addr;
  logic [W-1:0] din;
  logic [W-1:0] dout;
  logic [W-1:0] pad_in;
  logic [W-1:0] filt;
  logic         irq;

  always #5 clk = ~clk;

  gpio_in_filter dut (
    .clk    (clk),
    .resetn (resetn),
    .cs     (cs),
    .wen    (wen),
    .addr   (addr),
    .din    (din),
    .dout   (dout),
    .pad_in (pad_in),
    .filt   (filt),
    .irq    (irq)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: pad delay line, window of the last three tick samples, flags.
  logic [W-1:0] m_p1, m_p2;
  logic [W-1:0] m_w0, m_w1, m_w2;
  logic [W-1:0] m_filt, m_filt_prev, m_rise, m_fall;
  logic         m_irq;
  int           m_period;
  int           m_k;
  logic [W-1:0] obs_tick;

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_p1 = '0; m_p2 = '0;
    m_w0 = '0; m_w1 = '0; m_w2 = '0;
    m_filt = '0; m_filt_prev = '0; m_rise = '0; m_fall = '0;
    m_irq = 1'b0;
    m_period = 999;
    m_k = 0;
  endtask

  function automatic logic exp_tick();
    if (cs && wen && addr == 2'd1) return 1'b0;
    return (m_k % (m_period + 1)) == m_period;
  endfunction

  function automatic logic [W-1:0] m_read(input logic [1:0] a);
    case (a)
      2'd0:    return m_filt;
      2'd1:    return 32'(m_period);
      2'd2:    return m_rise;
      default: return m_fall;
    endcase
  endfunction

  task automatic model_edge();
    logic         wr, tk;
    logic [W-1:0] cr, cf;
    if (!resetn) begin
      model_reset();
      return;
    end
    wr = cs && wen;
    tk = exp_tick();
    cr = (wr && addr == 2'd2) ? din : '0;
    cf = (wr && addr == 2'd3) ? din : '0;
    m_rise = (m_rise & ~cr) | (m_filt & ~m_filt_prev);
    m_fall = (m_fall & ~cf) | (~m_filt & m_filt_prev);
    m_filt_prev = m_filt;
    if (tk) begin
      m_w2 = m_w1; m_w1 = m_w0; m_w0 = m_p2;
      m_filt = (m_w0 & m_w1 & m_w2) | (m_filt & (m_w0 | m_w1 | m_w2));
    end
    m_p2 = m_p1;
    m_p1 = pad_in;
    if (wr && addr == 2'd1) begin
      m_period = int'(din[15:0]);
      m_k = 0;
    end else begin
      m_k++;
    end
    m_irq = |{m_rise, m_fall};
  endtask

  task automatic step();
    @(negedge clk);
    chk("dout", dout, m_read(addr));
    obs_tick = 32'(dut.tick);
    if (resetn) chk("tick", obs_tick, 32'(exp_tick()));
    @(posedge clk);
    model_edge();
    #1;
    chk("filt", filt, m_filt);
    chk("irq", 32'(irq), 32'(m_irq));
  endtask

  task automatic idle(input int n);
    cs = 1'b0; wen = 1'b0;
    repeat (n) step();
  endtask

  task automatic wreg(input logic [1:0] a, input logic [W-1:0] d);
    cs = 1'b1; wen = 1'b1; addr = a; din = d;
    step();
    cs = 1'b0; wen = 1'b0;
  endtask

  task automatic do_reset();
    pad_in = '0;
    resetn = 1'b0;
    idle(2);
    resetn = 1'b1;
  endtask

  task automatic peek(input string tag, input logic [1:0] a, input logic [W-1:0] exp);
    addr = a;
    #1;
    chk(tag, dout, exp);
  endtask

  initial begin
    int guard;
    resetn = 1'b0; cs = 1'b0; wen = 1'b0; addr = 2'd0; din = '0; pad_in = '0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    resetn = 1'b1;
    chk("reset_filt", filt, 32'h0);
    chk("reset_irq", 32'(irq), 32'h0);
    peek("reset_period", 2'd1, 32'd999);

    // Basic propagation with period 0
    wreg(2'd1, 32'd0);
    pad_in = 32'h5;
    idle(4);
    chk("prop_early", filt, 32'h0);
    idle(1);
    chk("prop_filt", filt, 32'h5);
    idle(1);
    peek("prop_rise", 2'd2, 32'h5);
    chk("prop_irq", 32'(irq), 32'h1);

    // Glitch rejection: 4-cycle pulse with period 3
    do_reset();
    wreg(2'd1, 32'd3);
    idle(5);
    pad_in = 32'h1;
    idle(4);
    pad_in = 32'h0;
    idle(40);
    chk("glitch_filt", filt, 32'h0);
    peek("glitch_rise", 2'd2, 32'h0);

    // W1C and set-wins-over-clear
    do_reset();
    wreg(2'd1, 32'd0);
    pad_in = 32'h3;
    idle(7);
    peek("w1c_pre", 2'd2, 32'h3);
    wreg(2'd2, 32'h1);
    peek("w1c_clr", 2'd2, 32'h2);
    pad_in = 32'h1;
    idle(8);
    wreg(2'd2, 32'h2);
    peek("w1c_clr1", 2'd2, 32'h0);
    pad_in = 32'h3;
    guard = 0;
    while (!m_filt[1] && guard < 20) begin
      idle(1);
      guard++;
    end
    chk("w1c_settle", 32'(filt[1]), 32'h1);
    wreg(2'd2, 32'h2);
    peek("set_wins", 2'd2, 32'h2);

    // Falling edge and irq clear
    do_reset();
    wreg(2'd1, 32'd0);
    pad_in = 32'h10;
    idle(8);
    wreg(2'd2, 32'h10);
    pad_in = 32'h0;
    idle(8);
    peek("fall_set", 2'd3, 32'h10);
    chk("fall_irq", 32'(irq), 32'h1);
    wreg(2'd3, 32'h10);
    chk("irq_clr", 32'(irq), 32'h0);
    peek("fall_clr", 2'd3, 32'h0);

    // Period write mid-count, then reset with a pending change
    do_reset();
    idle(10);
    wreg(2'd1, 32'd2);
    for (int i = 0; i < 3; i++) begin
      idle(1);
      chk("tick_after_wr", obs_tick, 32'(i == 2));
    end
    pad_in = 32'hFF;
    idle(4);
    resetn = 1'b0;
    idle(1);
    resetn = 1'b1;
    chk("rst_filt", filt, 32'h0);
    peek("rst_rise", 2'd2, 32'h0);
    peek("rst_fall", 2'd3, 32'h0);
    peek("rst_period", 2'd1, 32'd999);
    idle(3);

    // Randomized traffic against the model
    do_reset();
    wreg(2'd1, 32'($urandom_range(0, 3)));
    for (int it = 0; it < 300; it++) begin
      int r;
      r = int'($urandom_range(0, 9));
      if (r < 6) begin
        pad_in = pad_in ^ ($urandom & $urandom);
        addr = 2'($urandom_range(0, 3));
        idle(int'($urandom_range(1, 12)));
      end else if (r < 8) begin
        wreg(2'($urandom_range(2, 3)), $urandom);
      end else if (r == 8) begin
        wreg(2'd1, 32'($urandom_range(0, 3)));
      end else begin
        wreg(2'd0, $urandom);
      end
    end
    idle(30);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/gpio_in_filter.md
# gpio_in_filter

Input conditioning stage placed directly upstream of `gpio_in`. It synchronises raw asynchronous pad inputs, debounces each bit against a programmable sample period, and latches rising/falling edge events into CPU-clearable flag registers with an interrupt output. The debounced vector `filt` drives `gpio_in.io_in`; the block also has its own small register window on the CPU bus.

## Interface
- `WIDTH`, 32: number of input bits.
- `CNT_W`, 16: width of the debounce prescaler and period register.
- `DEF_PERIOD`, 999: reset value of the period register.

- `clk`  in  1  system clock; all logic is single-clock.
- `resetn`  in  1  reset, synchronous and active-low.
- `cs`  in  1  register window select.
- `wen`  in  1  write enable; a write happens when `cs && wen`.
- `addr`  in  2  register index.
- `din`  in  WIDTH  write data.
- `dout`  out  WIDTH  read data, combinational from `addr`.
- `pad_in`  in  WIDTH  raw asynchronous inputs.
- `filt`  out  WIDTH  debounced value, connects to `gpio_in.io_in`.
- `irq`  out  1  OR of all rise and fall flags.

## Operation
- Synchroniser: a two-flop chain per bit, `s1 <= pad_in` and `s2 <= s1`. No reset dependence beyond clearing to 0.
- Prescaler: one shared counter `pcnt`.
  - When `pcnt == period`: `tick = 1` and `pcnt <= 0`.
  - Otherwise `pcnt <= pcnt + 1`.
  - `period = 0` gives a tick every cycle.
  - Any write to addr 1 loads `period <= din[CNT_W-1:0]` and forces `pcnt <= 0` in the same cycle. There is no tick that cycle.
- Debounce: each bit keeps two history bits `h[1:0]`. On `tick`:
  - `h <= {h[0], s2}`.
  - If `s2 == h[0] == h[1]` and `s2 != filt`, then `filt <= s2`.
  - A bit therefore changes only after 3 consecutive equal tick samples.
- Edge flags, `rise` and `fall` (WIDTH bits each):
  - In the cycle after `filt` goes 0→1 the matching `rise` bit sets; 1→0 sets the matching `fall` bit.
  - Writing addr 2 or 3 clears (write-1-to-clear) the bits where `din` is 1.
  - If a set and a clear hit the same bit in the same cycle, set wins.
- Register map (`dout`):
  - 0: `filt` (read-only; writes ignored).
  - 1: `period`, zero-extended.
  - 2: `rise` (W1C).
  - 3: `fall` (W1C).
- `irq = |rise | |fall`, registered from the flag registers with no extra delay.
- Reset values: `s1`, `s2`, `h`, `filt`, `rise`, `fall`, `pcnt`, `irq` = 0; `period = DEF_PERIOD`. `dout` reflects these values combinationally.
- Reset mid-operation: all state returns to reset values on the next edge, and a pending edge is lost. Because `filt` is forced to 0, no flag is raised by the reset itself.

## Timing
- Pad to `s2`: 2 cycles.
- Pad change to `filt` update: 2 cycles, plus the wait for the 3rd qualifying tick.
  - With `period = 0` and a stable input, the latency is 2 (sync) + 3 (history/filter update) = 5 cycles.
  - In the worst case, the latency is 2 + 3·(period+1) cycles.
- `filt` change to flag set: +1 cycle. `irq` follows the flag in the same cycle.
- Glitch rejection: a pulse shorter than 2 tick intervals never reaches `filt`.
- `dout` is valid combinationally in the same cycle as `addr`. A write becomes visible on `dout` from the next cycle.

## Structure
- Register index constants `REG_FILT`, `REG_PERIOD`, `REG_RISE`, `REG_FALL` go in the shared GPIO package, so `gpio_in` and software headers agree.
- One natural sub-module, `gpio_debounce_bit`: a single-bit synchroniser plus history plus filter. It takes `clk`, `resetn`, `tick`, `pad`, and outputs `filt`. It is instantiated WIDTH times in a generate loop.
- The prescaler, flags and register mux stay in the top module.

## Test plan
- Reset check: hold `resetn = 0` for 2 cycles, then release. Required: `filt = 0`, `irq = 0`, and reading addr 1 returns 999.
- Basic propagation: write `period = 0`, then drive `pad_in = 0x0000_0005`. Required: `filt = 0x5` exactly 5 cycles later; `rise = 0x5` and `irq = 1` one cycle after that.
- Glitch rejection: with `period = 3`, drive a 4-cycle pulse on bit 0. Required: `filt[0]` stays 0 and `rise = 0`.
- W1C and simultaneous set: with `rise = 0x3`, write addr 2 with `0x1`. Required: `rise = 0x2`. Then write 1 to bit 1 in the same cycle its rise sets again. Required: bit 1 stays 1.
- Falling edge and irq clear: drive bit 4 high and let it settle, clear `rise`, then drive it low. Required: `fall = 0x10` and `irq = 1`. Write `0x10` to addr 3. Required: `irq = 0`.
- Period write and reset mid-debounce: write `period = 2` mid-count. Required: the next tick comes exactly 3 cycles after the write. Then assert `resetn` while a pad change is pending. Required: `filt = 0`, no flags set, and `period = 999`.
